// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - requester and response channels of the shared shifter
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_funct;
  logic [31:0] req0_a;
  logic [4:0]  req0_n;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_funct;
  logic [31:0] req1_a;
  logic [4:0]  req1_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_r;
  logic        rsp_id;

  modport master (
    output req0_valid, req0_funct, req0_a, req0_n,
    output req1_valid, req1_funct, req1_a, req1_n,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_r, rsp_id
  );

  modport slave (
    input  req0_valid, req0_funct, req0_a, req0_n,
    input  req1_valid, req1_funct, req1_a, req1_n,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_r, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin shared multi-cycle shifter, STEP bits per cycle
module shift_arbiter #(
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state, state_nx;
  logic        last_grant;
  logic        id_q;
  logic [1:0]  funct_q;
  logic [31:0] work;
  logic [31:0] rsp_r_q;
  logic [4:0]  rem;

  logic        grant0, grant1, accept, acc_id;
  logic [1:0]  acc_funct;
  logic [31:0] acc_a;
  logic [4:0]  acc_n;
  logic [5:0]  k;
  logic        last_step;
  logic [31:0] stepped;

  // The requester that was not granted last time wins a tie.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  assign k         = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
  assign last_step = ({1'b0, rem} <= STEP_W);

  // The working register keeps the original sign in bit 31, so >>> refills it correctly.
  always_comb begin
    case (funct_q)
      2'b00:   stepped = work << k;
      2'b11:   stepped = $signed(work) >>> k;
      default: stepped = work >> k;
    endcase
  end

  always_comb begin
    state_nx       = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    accept         = 1'b0;
    acc_id         = !grant0;
    acc_funct      = grant0 ? bus.req0_funct : bus.req1_funct;
    acc_a          = grant0 ? bus.req0_a     : bus.req1_a;
    acc_n          = grant0 ? bus.req0_n     : bus.req1_n;
    case (state)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 || grant1) begin
          accept   = 1'b1;
          state_nx = (acc_funct == 2'b01 || acc_n == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      funct_q    <= 2'b00;
      work       <= 32'd0;
      rem        <= 5'd0;
      rsp_r_q    <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            funct_q    <= acc_funct;
            id_q       <= acc_id;
            last_grant <= acc_id;
            work       <= acc_a;
            rem        <= acc_n;
            if (acc_funct == 2'b01)  rsp_r_q <= 32'd0;
            else if (acc_n == 5'd0)  rsp_r_q <= acc_a;
          end
        end
        SHIFT: begin
          work <= stepped;
          rem  <= rem - k[4:0];
          if (last_step) rsp_r_q <= stepped;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state != IDLE);
endmodule
